// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port,
// with a per-register busy scoreboard and a saturating contention counter.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [ADDR_WIDTH-1:0]      a_rd,
    input  logic [DATA_WIDTH-1:0]      a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [ADDR_WIDTH-1:0]      b_rd,
    input  logic [DATA_WIDTH-1:0]      b_data,
    input  logic                       alloc_valid,
    input  logic [ADDR_WIDTH-1:0]      alloc_rd,
    output logic [(1<<ADDR_WIDTH)-1:0] busy_mask,
    output logic [ADDR_WIDTH-1:0]      rf_write_reg,
    output logic                       rf_write_enable,
    output logic [DATA_WIDTH-1:0]      rf_write_data,
    output logic [CNT_WIDTH-1:0]       conflict_count
);
    localparam int NREG = 1 << ADDR_WIDTH;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // prio = 0 favours A, 1 favours B when both are valid
    logic                  prio;
    logic                  transfer_p0;
    logic [ADDR_WIDTH-1:0] wr_rd_p0;
    logic [DATA_WIDTH-1:0] wr_data_p0;
    logic [NREG-1:0]       busy_next;

    assign a_ready     = a_valid && (!b_valid || !prio);
    assign b_ready     = b_valid && (!a_valid || prio);
    assign transfer_p0 = a_valid || b_valid;
    assign wr_rd_p0    = b_ready ? b_rd   : a_rd;
    assign wr_data_p0  = b_ready ? b_data : a_data;

    // Stage p0 -> p1: winning write-back registered onto the write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio            <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_write_reg    <= '0;
            rf_write_data   <= '0;
        end else if (transfer_p0) begin
            prio            <= a_ready;
            rf_write_enable <= (wr_rd_p0 != '0);
            rf_write_reg    <= wr_rd_p0;
            rf_write_data   <= wr_data_p0;
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

    // Clear on the register-file write edge; a same-edge alloc re-marks the bit busy
    always_comb begin
        busy_next = busy_mask;
        if (rf_write_enable)
            busy_next[rf_write_reg] = 1'b0;
        if (alloc_valid)
            busy_next[alloc_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_mask      <= '0;
            conflict_count <= '0;
        end else begin
            busy_mask <= busy_next;
            if (a_valid && b_valid)
                conflict_count <= sat_inc(conflict_count);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued by the
// stimulus and popped by a write-port monitor; other outputs checked inline.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, alloc_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, alloc_rd;
    logic [31:0] a_data, b_data;
    logic [31:0] busy_mask;
    logic [4:0]  rf_write_reg;
    logic        rf_write_enable;
    logic [31:0] rf_write_data;
    logic [15:0] conflict_count;

    int compared = 0;
    int failed   = 0;
    logic [36:0] exp_q[$];
    logic [31:0] rf_model [32] = '{default: '0};

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .busy_mask(busy_mask),
        .rf_write_reg(rf_write_reg), .rf_write_enable(rf_write_enable),
        .rf_write_data(rf_write_data), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    // Register file stand-in, written from the DUT's write port
    always @(posedge clk)
        if (rf_write_enable) rf_model[rf_write_reg] <= rf_write_data;

    // Monitor: every enabled write must match the next queued expectation
    always @(negedge clk) begin
        if (!reset && rf_write_enable) begin
            compared++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL wr_unexpected: got reg=%0d data=%0h, required no write",
                         rf_write_reg, rf_write_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_write_reg, rf_write_data} !== e) begin
                    failed++;
                    $display("FAIL wr_port: got reg=%0d data=%0h, required reg=%0d data=%0h",
                             rf_write_reg, rf_write_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; b_valid = 0; alloc_valid = 0;
        a_rd = 0; b_rd = 0; alloc_rd = 0; a_data = 0; b_data = 0;
        tick();
        // ready follows valid during reset, but nothing is written
        a_valid = 1; a_rd = 3; a_data = 32'h33;
        #1 check("ready_in_reset", a_ready, 1);
        tick();
        check("no_write_in_reset", rf_write_enable, 0);
        a_valid = 0;
        #1 reset = 1'b0;
        #1;
        check("rst_wen", rf_write_enable, 0);
        check("rst_reg", rf_write_reg, 0);
        check("rst_data", rf_write_data, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_cnt", conflict_count, 0);
        tick();

        // Single A write to x5
        a_valid = 1; a_rd = 5; a_data = 32'h55;
        #1 check("a_only_ready", {a_ready, b_ready}, 2'b10);
        exp_q.push_back({5'd5, 32'h55});
        tick();
        a_valid = 0;
        check("a_only_wen", rf_write_enable, 1);
        tick();
        check("rf_x5", rf_model[5], 32'h55);

        // Pulse reset to return prio to A, then alternate grants
        reset = 1; #1 reset = 0;
        a_valid = 1; a_rd = 1; a_data = 32'h11;
        b_valid = 1; b_rd = 2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i % 2 == 0) begin
                check($sformatf("alt_grant%0d", i), {a_ready, b_ready}, 2'b10);
                exp_q.push_back({5'd1, 32'h11});
            end else begin
                check($sformatf("alt_grant%0d", i), {a_ready, b_ready}, 2'b01);
                exp_q.push_back({5'd2, 32'h22});
            end
            tick();
        end
        a_valid = 0; b_valid = 0;
        #1 check("conflict4", conflict_count, 4);
        tick();

        // Allocate x7, then clear it via a B write
        alloc_valid = 1; alloc_rd = 7;
        tick();
        alloc_valid = 0;
        check("busy7_set", busy_mask, 32'h80);
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        #1 check("b_only_ready", {a_ready, b_ready}, 2'b01);
        exp_q.push_back({5'd7, 32'h77});
        tick();
        b_valid = 0;
        check("busy7_during_wen", busy_mask, 32'h80);
        tick();
        check("busy7_cleared", busy_mask, 0);

        // Same-edge write and alloc of x9: set wins
        alloc_valid = 1; alloc_rd = 9;
        tick();
        alloc_valid = 0;
        a_valid = 1; a_rd = 9; a_data = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        tick();
        a_valid = 0;
        alloc_valid = 1; alloc_rd = 9;
        tick();
        check("busy9_collision", busy_mask, 32'h200);
        alloc_rd = 0;
        tick();
        alloc_valid = 0;
        check("busy0_never", busy_mask, 32'h200);

        // Write to x0 is accepted but suppressed
        a_valid = 1; a_rd = 0; a_data = 32'hFF;
        #1 check("x0_ready", a_ready, 1);
        tick();
        a_valid = 0;
        check("x0_wen", rf_write_enable, 0);
        tick();
        check("rf_x0", rf_model[0], 0);

        // Asynchronous reset while a write is in flight
        a_valid = 1; a_rd = 12; a_data = 32'hC;
        alloc_valid = 1; alloc_rd = 13;
        tick();
        a_valid = 0; alloc_valid = 0;
        check("inflight_wen", rf_write_enable, 1);
        check("inflight_busy", busy_mask, 32'h2200);
        #1 reset = 1;
        #1;
        check("async_wen", rf_write_enable, 0);
        check("async_reg", rf_write_reg, 0);
        check("async_data", rf_write_data, 0);
        check("async_busy", busy_mask, 0);
        reset = 0;
        tick();
        check("rf_x12_untouched", rf_model[12], 0);

        // Saturation of the contention counter (x0 targets keep the port quiet)
        a_valid = 1; a_rd = 0; b_valid = 1; b_rd = 0;
        #1 check("prio_after_reset", {a_ready, b_ready}, 2'b10);
        for (int i = 0; i < 65534; i++) tick();
        check("cnt_near_sat", conflict_count, 16'hFFFE);
        for (int i = 0; i < 4466; i++) tick();
        check("cnt_saturated", conflict_count, 16'hFFFF);
        a_valid = 0; b_valid = 0;
        tick();
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
